// File: rtl/writeback_stage.sv
// writeback_stage
// Retires packed result records {data, address, opcode} coming from the
// decode/execute stage. Each record goes to RAM, to the GPR file, or is
// discarded, depending on its opcode. A small FIFO absorbs records while
// a RAM write waits for its grant. Back-pressure goes back to decode.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   complex_data   record: [top DATA_W]=data, [next ADDR_W]=address, [3:0]=opcode
//   data_write     record valid strobe (captured on its rising edge)
//   pause_DECODE   stall request to decode (registered count >= FIFO_DEPTH-1)
//   ram_wr         RAM write request, held until ram_garant_wr is sampled 1
//   ram_garant_wr  RAM write grant
//   addr_out       RAM write address
//   data_out       RAM write data
//   GPR_wr         GPR write enable (single-cycle pulse)
//   addr_GPRout    GPR write address
//   data_GPRout    GPR write data
//   overflow       sticky flag: a record arrived while the FIFO was full
//   retired_count  number of records retired, discards included; wraps
module writeback_stage #(
    parameter int          DATA_W        = 14,
    parameter int          ADDR_W        = 12,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [15:0] DEST_RAM_MASK = 16'h0000,
    parameter logic [15:0] DEST_GPR_MASK = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W+ADDR_W+3:0] complex_data,
    input  logic                     data_write,
    output logic                     pause_DECODE,
    output logic                     ram_wr,
    input  logic                     ram_garant_wr,
    output logic [ADDR_W-1:0]        addr_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     GPR_wr,
    output logic [ADDR_W-1:0]        addr_GPRout,
    output logic [DATA_W-1:0]        data_GPRout,
    output logic                     overflow,
    output logic [15:0]              retired_count
);
    localparam int REC_W = DATA_W + ADDR_W + 4;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] PAUSE_LVL_C = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GPR_WR  = 2'd1,
        RAM_REQ = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [REC_W-1:0]  fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              data_write_q_r;
    logic              push_s;
    logic              push_ok_s;
    logic              pop_s;
    logic              load_ram_s;
    logic              load_gpr_s;
    logic [REC_W-1:0]  head_s;
    logic [3:0]        head_op_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;

    // Head record fields and the capture strobe (only the rising edge of data_write pushes).
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign head_op_s   = head_s[3:0];
    assign head_addr_s = head_s[ADDR_W+3:4];
    assign head_data_s = head_s[REC_W-1:ADDR_W+4];
    assign push_s      = data_write & ~data_write_q_r;
    // A full FIFO drops the record even if the head pops in the same cycle.
    assign push_ok_s   = push_s & (count_r != DEPTH_C);

    // Next-state and retire decisions; RAM takes precedence over GPR.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        load_ram_s   = 1'b0;
        load_gpr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    if (DEST_RAM_MASK[head_op_s]) begin
                        load_ram_s   = 1'b1;
                        state_next_s = RAM_REQ;
                    end else if (DEST_GPR_MASK[head_op_s]) begin
                        load_gpr_s   = 1'b1;
                        state_next_s = GPR_WR;
                    end else begin
                        pop_s        = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            GPR_WR: begin
                pop_s        = 1'b1;
                state_next_s = IDLE;
            end
            RAM_REQ: begin
                if (ram_garant_wr) begin
                    pop_s        = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RAM_REQ;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Record FIFO: storage, pointers, occupancy and capture edge register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {REC_W{1'b0}};
            end
            wr_ptr_r       <= {PTR_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            count_r        <= {CNT_W{1'b0}};
            data_write_q_r <= 1'b0;
        end else begin
            data_write_q_r <= data_write;
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= complex_data;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered outputs: write strobes follow the next state, payloads load on dispatch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_DECODE  <= 1'b0;
            ram_wr        <= 1'b0;
            addr_out      <= {ADDR_W{1'b0}};
            data_out      <= {DATA_W{1'b0}};
            GPR_wr        <= 1'b0;
            addr_GPRout   <= {ADDR_W{1'b0}};
            data_GPRout   <= {DATA_W{1'b0}};
            overflow      <= 1'b0;
            retired_count <= 16'd0;
        end else begin
            // One slot of margin covers decode's one-cycle reaction to pause.
            pause_DECODE <= (count_r >= PAUSE_LVL_C);
            ram_wr       <= (state_next_s == RAM_REQ);
            GPR_wr       <= (state_next_s == GPR_WR);
            if (load_ram_s) begin
                addr_out <= head_addr_s;
                data_out <= head_data_s;
            end
            if (load_gpr_s) begin
                addr_GPRout <= head_addr_s;
                data_GPRout <= head_data_s;
            end
            if (push_s && !push_ok_s) begin
                overflow <= 1'b1;
            end
            if (pop_s) begin
                retired_count <= retired_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
    localparam logic [15:0] RAM_MASK = 16'h0031; // ops 0,4,5 (op 4 also GPR: RAM wins)
    localparam logic [15:0] GPR_MASK = 16'h0118; // ops 3,4,8

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] complex_data;
    logic        data_write;
    logic        pause_DECODE;
    logic        ram_wr;
    logic        ram_garant_wr;
    logic [11:0] addr_out;
    logic [13:0] data_out;
    logic        GPR_wr;
    logic [11:0] addr_GPRout;
    logic [13:0] data_GPRout;
    logic        overflow;
    logic [15:0] retired_count;

    int checks = 0;
    int errors = 0;

    writeback_stage #(
        .DATA_W(14), .ADDR_W(12), .FIFO_DEPTH(4),
        .DEST_RAM_MASK(RAM_MASK), .DEST_GPR_MASK(GPR_MASK)
    ) dut (
        .clk(clk), .reset(reset), .complex_data(complex_data), .data_write(data_write),
        .pause_DECODE(pause_DECODE), .ram_wr(ram_wr), .ram_garant_wr(ram_garant_wr),
        .addr_out(addr_out), .data_out(data_out), .GPR_wr(GPR_wr),
        .addr_GPRout(addr_GPRout), .data_GPRout(data_GPRout),
        .overflow(overflow), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Queue holds every record not yet retired (including the one being written).
    typedef struct packed {
        logic [13:0] d;
        logic [11:0] a;
        logic [3:0]  op;
    } rec_t;

    rec_t        q[$];
    int          in_flight;     // 0: head not dispatched, 1: GPR write, 2: RAM write
    logic        m_dw_prev;
    logic        e_ram_wr, e_gpr_wr, e_pause, e_ovf;
    logic [11:0] e_addr, e_gaddr;
    logic [13:0] e_data, e_gdata;
    logic [15:0] e_retired;

    task automatic model_clear();
        q.delete();
        in_flight = 0;
        m_dw_prev = 1'b0;
        e_ram_wr  = 1'b0;
        e_gpr_wr  = 1'b0;
        e_pause   = 1'b0;
        e_ovf     = 1'b0;
        e_retired = 16'd0;
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            automatic bit push = data_write && !m_dw_prev;
            automatic int pre  = q.size();
            automatic bit pop  = 1'b0;
            if (in_flight == 0) begin
                if (pre > 0) begin
                    if (RAM_MASK[q[0].op]) begin
                        in_flight = 2; e_ram_wr = 1'b1; e_addr = q[0].a; e_data = q[0].d;
                    end else if (GPR_MASK[q[0].op]) begin
                        in_flight = 1; e_gpr_wr = 1'b1; e_gaddr = q[0].a; e_gdata = q[0].d;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end else if (in_flight == 1) begin
                pop = 1'b1; e_gpr_wr = 1'b0; in_flight = 0;
            end else if (ram_garant_wr) begin
                pop = 1'b1; e_ram_wr = 1'b0; in_flight = 0;
            end
            e_pause = (pre >= 3);
            if (pop) begin
                void'(q.pop_front());
                e_retired = e_retired + 16'd1;
            end
            if (push) begin
                if (pre < 4) q.push_back(rec_t'(complex_data));
                else e_ovf = 1'b1;
            end
            m_dw_prev = data_write;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("ram_wr", 32'(ram_wr), 32'(e_ram_wr));
        check("GPR_wr", 32'(GPR_wr), 32'(e_gpr_wr));
        check("pause_DECODE", 32'(pause_DECODE), 32'(e_pause));
        check("overflow", 32'(overflow), 32'(e_ovf));
        check("retired_count", 32'(retired_count), 32'(e_retired));
        if (e_ram_wr) begin
            check("addr_out", 32'(addr_out), 32'(e_addr));
            check("data_out", 32'(data_out), 32'(e_data));
        end
        if (e_gpr_wr) begin
            check("addr_GPRout", 32'(addr_GPRout), 32'(e_gaddr));
            check("data_GPRout", 32'(data_GPRout), 32'(e_gdata));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [13:0] d, input logic [11:0] a, input logic [3:0] op);
        complex_data = {d, a, op};
        data_write   = 1'b1;
        step();
        data_write   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; data_write = 1'b0; ram_garant_wr = 1'b0; complex_data = 30'd0;
        model_clear();
        #3;
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_GPR_wr", 32'(GPR_wr), 32'd0);
        check("rst_retired", 32'(retired_count), 32'd0);
        step(); step();
        reset = 1'b0;
        step();

        // Single GPR record: pulse one cycle after the push.
        push(14'h155, 12'h300, 4'd3);
        step();
        check("gpr_pulse", 32'(GPR_wr), 32'd1);
        check("gpr_addr", 32'(addr_GPRout), 32'h300);
        check("gpr_data", 32'(data_GPRout), 32'h155);
        step();
        check("gpr_pulse_end", 32'(GPR_wr), 32'd0);
        check("gpr_retired", 32'(retired_count), 32'd1);

        // RAM record with a five-cycle grant wait.
        push(14'h2AA, 12'h0F0, 4'd0);
        step();
        check("ram_req", 32'(ram_wr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("ram_hold", 32'(ram_wr), 32'd1);
            check("ram_hold_addr", 32'(addr_out), 32'h0F0);
            check("ram_hold_data", 32'(data_out), 32'h2AA);
        end
        ram_garant_wr = 1'b1;
        step();
        ram_garant_wr = 1'b0;
        check("ram_drop", 32'(ram_wr), 32'd0);
        check("ram_retired", 32'(retired_count), 32'd2);

        // Strobe held four cycles: one discard.
        complex_data = {14'h001, 12'h001, 4'd2};
        data_write = 1'b1;
        repeat (4) step();
        data_write = 1'b0;
        step(); step();
        check("held_strobe_retired", 32'(retired_count), 32'd3);

        // Push on the cycle the GPR head pops.
        complex_data = {14'h0AA, 12'h011, 4'd3};
        data_write = 1'b1;
        step();
        data_write = 1'b0;
        step();
        check("pp_first_addr", 32'(addr_GPRout), 32'h011);
        complex_data = {14'h0BB, 12'h022, 4'd8};
        data_write = 1'b1;
        step();
        data_write = 1'b0;
        check("pp_gap", 32'(GPR_wr), 32'd0);
        step();
        check("pp_second", 32'(GPR_wr), 32'd1);
        check("pp_second_addr", 32'(addr_GPRout), 32'h022);
        step();
        check("pp_retired", 32'(retired_count), 32'd5);
        check("pp_no_overflow", 32'(overflow), 32'd0);

        // Five RAM pushes, no grant: fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            push(14'(14'h100 + i), 12'(12'h040 + i), 4'd0);
            step();
        end
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_pause", 32'(pause_DECODE), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_order_req", 32'(ram_wr), 32'd1);
            check("ovf_order_addr", 32'(addr_out), 32'(12'h040 + i));
            ram_garant_wr = 1'b1;
            step();
            ram_garant_wr = 1'b0;
            step();
        end
        check("ovf_drained", 32'(ram_wr), 32'd0);
        check("ovf_retired", 32'(retired_count), 32'd9);

        // Reset while a RAM write is pending.
        push(14'h3FF, 12'h123, 4'd5);
        step();
        check("pre_reset_req", 32'(ram_wr), 32'd1);
        reset = 1'b1;
        model_clear();
        #1;
        check("async_ram_wr", 32'(ram_wr), 32'd0);
        check("async_pause", 32'(pause_DECODE), 32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        check("async_retired", 32'(retired_count), 32'd0);
        step(); step();
        reset = 1'b0;
        ram_garant_wr = 1'b1;
        step();
        ram_garant_wr = 1'b0;
        step();
        check("post_reset_grant", 32'(ram_wr), 32'd0);
        check("post_reset_retired", 32'(retired_count), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            data_write    = 1'($urandom_range(0, 1));
            complex_data  = 30'($urandom);
            ram_garant_wr = ($urandom_range(0, 3) == 0);
            if (i == 300) begin
                reset = 1'b1;
                model_clear();
            end
            if (i == 302) reset = 1'b0;
            step();
        end
        data_write = 1'b0;
        ram_garant_wr = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Consumes the packed result records produced by the decode/execute stage and retires them to the destination: RAM, the GPR file, or discard.
- A record is `{data, address, opcode}` and arrives with the `data_write` strobe.
- A small FIFO absorbs records while RAM is busy.
- Back-pressure is returned to the decode stage through `pause_DECODE`.

Parameters:
- DATA_W, 14, data word width.
- ADDR_W, 12, RAM/GPR address width.
- FIFO_DEPTH, 4, record buffer depth; power of two, ≥2.
- DEST_RAM_MASK, 16'h0000, bit i = 1: opcode i retires to RAM.
- DEST_GPR_MASK, 16'h0000, bit i = 1: opcode i retires to GPR.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- complex_data  in  DATA_W+ADDR_W+4  record: [top DATA_W]=data, [next ADDR_W]=address, [3:0]=opcode.
- data_write  in  1  record valid strobe from decode.
- pause_DECODE  out  1  stall request to decode.
- ram_wr  out  1  RAM write request.
- ram_garant_wr  in  1  RAM write grant/accept.
- addr_out  out  ADDR_W  RAM write address.
- data_out  out  DATA_W  RAM write data.
- GPR_wr  out  1  GPR write enable.
- addr_GPRout  out  ADDR_W  GPR write address.
- data_GPRout  out  DATA_W  GPR write data.
- overflow  out  1  sticky: a record was dropped.
- retired_count  out  16  records retired, including discards; wraps.

Behaviour:
- Reset: one clock `clk`; reset `reset` is asynchronous and active-high.
  - All outputs go 0 immediately.
  - FIFO is emptied and the `data_write` edge register is cleared.
  - FSM goes to IDLE.
  - Reset mid-RAM-transaction abandons the write; `ram_wr` drops asynchronously.
- Capture:
  - A record is pushed on the rising edge of `data_write` (`data_write`=1 and its registered copy=0).
  - A strobe held high for several cycles (decode paused) pushes exactly once.
- Full:
  - A push when count==FIFO_DEPTH drops the record and sets `overflow` (cleared only by reset).
- Back-pressure:
  - `pause_DECODE` = registered (count ≥ FIFO_DEPTH-1), updated every cycle.
  - This gives one slot of margin for the one-cycle pause latency.
- Push and pop in the same cycle: count unchanged; no overflow unless the FIFO was full before the pop.
- FSM states: IDLE, GPR_WR, RAM_REQ.
- IDLE, count>0: classify the head record by opcode.
  - DEST_RAM_MASK[opcode] → load `addr_out`/`data_out` from the head, assert `ram_wr`, go to RAM_REQ. RAM wins if both mask bits are set.
  - Else DEST_GPR_MASK[opcode] → load `addr_GPRout`/`data_GPRout`, assert `GPR_wr`, go to GPR_WR.
  - Else discard: pop, increment `retired_count`, stay in IDLE.
- GPR_WR: `GPR_wr` is high for exactly this one cycle. At the end of the cycle: pop, increment count, deassert `GPR_wr`, go to IDLE.
- RAM_REQ:
  - `ram_wr`, `addr_out`, `data_out` stay stable until `ram_garant_wr` is sampled 1.
  - On that edge: pop, increment, deassert `ram_wr`, go to IDLE.
  - No timeout; waiting indefinitely is legal.
  - A grant received outside RAM_REQ is ignored.
- Latency: a record pushed at edge E0 into an empty FIFO drives `GPR_wr`/`ram_wr` high from edge E1.
- Throughput:
  - GPR: one write per 2 cycles.
  - RAM: 2 cycles + grant wait.
  - Discard: 1 per cycle.
- Order: records retire strictly in FIFO order; RAM and GPR writes never overlap.
- Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Opcode 4'hF with both mask bits 0 is discarded like any other unmapped opcode.

Test Plan:
- DEST_GPR_MASK bit 3 set; one record data=14'h155, addr=12'h300, op=3 → `GPR_wr` high for exactly 1 cycle starting 1 cycle after the push, with `addr_GPRout`=12'h300, `data_GPRout`=14'h155; `retired_count`=1.
- DEST_RAM_MASK bit 0 set; record data=14'h2AA, addr=12'h0F0, op=0; `ram_garant_wr` held 0 for 5 cycles, then pulsed 1 → `ram_wr`, `addr_out`=12'h0F0, `data_out`=14'h2AA held stable 6 cycles; drops the cycle after the grant.
- `data_write` held high 4 cycles → exactly one push; `retired_count` increments by 1.
- 5 back-to-back pushes to RAM opcode with no grant, FIFO_DEPTH=4 → `pause_DECODE` high once count=3; 5th push dropped; `overflow`=1; granting 4 times retires the 4 stored records in order.
- Push on the same cycle the head pops (GPR) → count unchanged; no overflow; both records retire in order.
- Assert `reset` while `ram_wr`=1 → `ram_wr`, `pause_DECODE`, `overflow`, `retired_count` go 0 immediately without a clock edge; FIFO empty; a later grant has no effect.
